alib_fifo_packer: RTL and testbench

- Downstream drain stage for alib_circular_fifo.
- Pops WIDTH-bit entries from the FIFO read port (rd_en/data_out/empty) and packs RATIO consecutive entries into one wide word.
- Presents each packed word on a valid/ready stream toward wide consumers (DMA/AXI-stream adapters).
- Supports an explicit flush that emits a partial word.

---
 rtl/alib_fifo_packer_pkg.sv | 27 ++
 rtl/alib_fifo_packer_outreg.sv | 50 +++++
 rtl/alib_fifo_packer.sv | 133 +++++++++++++
 tb/tb_alib_fifo_packer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alib_fifo_packer_pkg.sv
// Purpose: shared types, defaults and helpers for the alib_fifo_packer drain stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alib_fifo_packer_pkg;

    // Packer control states: normal filling, or waiting to close a flushed word.
    typedef enum logic {
        FILL       = 1'b0,
        FLUSH_WAIT = 1'b1
    } state_t;

    localparam int WIDTH_DEF   = 8;
    localparam int RATIO_DEF   = 4;
    localparam int TIMEOUT_DEF = 64;
    localparam int OUT_W       = WIDTH_DEF * RATIO_DEF;

    // Bits needed to hold values 0..v-1 (at least 1); bounded loop so it elaborates anywhere.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (v > (1 << i)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/alib_fifo_packer_outreg.sv
// Purpose: single-entry valid/ready holding register for packed word, count and last flag.
// Latency: 1 cycle from load to m_valid; back-to-back drain and reload in the same cycle.
// Backpressure: contents held stable while m_valid && !m_ready; o_free tells the producer when a load is accepted.
module alib_fifo_packer_outreg #(
    parameter int DW = 32,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [DW-1:0] i_dat,
    input  logic [CW-1:0] i_cnt,
    input  logic          i_last,
    output logic          o_free,
    output logic [DW-1:0] m_data,
    output logic [CW-1:0] m_count,
    output logic          m_last,
    output logic          m_valid,
    input  logic          m_ready
);

    logic          r_vld;
    logic [DW-1:0] r_dat;
    logic [CW-1:0] r_cnt;
    logic          r_last;

    assign o_free  = !r_vld || m_ready;
    assign m_valid = r_vld;
    assign m_data  = r_dat;
    assign m_count = r_cnt;
    assign m_last  = r_last;

    // Load a new word when free; otherwise drop valid once the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_dat  <= '0;
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else if (i_load && o_free) begin
            r_vld  <= 1'b1;
            r_dat  <= i_dat;
            r_cnt  <= i_cnt;
            r_last <= i_last;
        end else if (m_ready) begin
            r_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/alib_fifo_packer.sv
// Purpose: pops WIDTH-bit FIFO entries and packs RATIO of them into one word; flush emits a partial word (ALIB_FIFO_PACKER_TIMEOUT_EN adds an idle auto-flush).
// Latency: one FIFO read in flight at a time; word appears 1 cycle after the last capture (2 after a flush closes it).
// Backpressure: a held output word stalls reads once the accumulator is full; m_valid/m_data/m_count/m_last hold until m_ready.
module alib_fifo_packer
    import alib_fifo_packer_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int RATIO   = RATIO_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             fifo_data_out,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic                         flush,
    output logic [WIDTH*RATIO-1:0]       m_data,
    output logic [clog2(RATIO+1)-1:0]    m_count,
    output logic                         m_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         busy
);

    localparam int PACK_W = WIDTH * RATIO;
    localparam int CNT_W  = clog2(RATIO + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RATIO);
    localparam logic [CNT_W:0]   RATIO_EXT = (CNT_W + 1)'(RATIO);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_acc_cnt;
    logic [PACK_W-1:0]   r_acc_dat;
    logic                r_inflight;
    logic                w_rd_en;
    logic                w_close;
    logic                w_close_last;
    logic                w_out_free;
    logic                w_flush_req;

`ifdef ALIB_FIFO_PACKER_TIMEOUT_EN
    localparam int TMO_W = clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_CNT = TMO_W'(TIMEOUT);
    logic [TMO_W-1:0] r_idle_cnt;
    logic             w_idle;

    assign w_idle      = (r_acc_cnt != '0) && fifo_empty && (r_state == FILL) && !r_inflight;
    assign w_flush_req = flush || (r_idle_cnt == TMO_CNT);

    // Idle counter: counts starved cycles with a partial word, saturates at TIMEOUT, clears on capture.
    always_ff @(posedge clk) begin
        if (rst || !w_idle) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TMO_CNT) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_flush_req = flush;
`endif

    // Never keep more reads outstanding than lanes left; no reads while a flush is being resolved.
    assign w_rd_en = !fifo_empty && !rst && (r_state == FILL)
                   && (({1'b0, r_acc_cnt} + {{CNT_W{1'b0}}, r_inflight}) < RATIO_EXT);
    assign fifo_rd_en = w_rd_en;
    assign busy       = (r_acc_cnt != '0) || r_inflight || m_valid;

    // Next state and word-close decision; a flush seen on a closing full word just marks it last.
    always_comb begin
        w_state_nxt  = r_state;
        w_close      = 1'b0;
        w_close_last = 1'b0;
        case (r_state)
            FILL: begin
                if ((r_acc_cnt == FULL_CNT) && w_out_free) begin
                    w_close      = 1'b1;
                    w_close_last = w_flush_req;
                end else if (w_flush_req) begin
                    w_state_nxt = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (!r_inflight && w_out_free) begin
                    w_state_nxt = FILL;
                    if (r_acc_cnt != '0) begin
                        w_close      = 1'b1;
                        w_close_last = 1'b1;
                    end
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Accumulator: capture the in-flight entry into the next lane, clear everything on close.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FILL;
            r_inflight <= 1'b0;
            r_acc_cnt  <= '0;
            r_acc_dat  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_rd_en;
            if (w_close) begin
                r_acc_cnt <= '0;
                r_acc_dat <= '0;
            end else if (r_inflight) begin
                r_acc_dat[int'(r_acc_cnt)*WIDTH +: WIDTH] <= fifo_data_out;
                r_acc_cnt <= r_acc_cnt + 1'b1;
            end
        end
    end

    alib_fifo_packer_outreg #(
        .DW (PACK_W),
        .CW (CNT_W)
    ) u_outreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_close),
        .i_dat   (r_acc_dat),
        .i_cnt   (r_acc_cnt),
        .i_last  (w_close_last),
        .o_free  (w_out_free),
        .m_data  (m_data),
        .m_count (m_count),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

endmodule

// File: tb/tb_alib_fifo_packer.sv
// Purpose: self-checking bench for alib_fifo_packer fed by a 16-deep, 8-bit FIFO model.
// Latency: n/a.
// Backpressure: exercises m_ready stalls and release.
module tb_alib_fifo_packer;

    localparam int WIDTH   = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  c;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  fifo_data_out;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        flush;
    logic [31:0] m_data;
    logic [2:0]  m_count;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic        busy;

    always #5 clk = ~clk;

    alib_fifo_packer #(
        .WIDTH   (WIDTH),
        .RATIO   (RATIO),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .flush         (flush),
        .m_data        (m_data),
        .m_count       (m_count),
        .m_last        (m_last),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy)
    );

    // Source FIFO model: registered read data, valid the cycle after fifo_rd_en.
    logic [7:0] mem [16];
    logic [3:0] wp, rp;
    logic [4:0] fcnt;
    logic       wr_en;
    logic [7:0] wr_dat;
    logic       fifo_clr;
    int         pop_cnt;
    logic       wr_ok;

    assign fifo_empty = (fcnt == 5'd0);
    assign wr_ok      = wr_en && (fcnt != 5'd16);

    always @(posedge clk) begin
        if (fifo_clr) begin
            wp <= '0; rp <= '0; fcnt <= '0; fifo_data_out <= '0; pop_cnt <= 0;
        end else begin
            if (wr_ok) begin
                mem[wp] <= wr_dat;
                wp <= wp + 1'b1;
            end
            if (fifo_rd_en) begin
                fifo_data_out <= mem[rp];
                rp <= rp + 1'b1;
                pop_cnt <= pop_cnt + 1;
            end
            case ({wr_ok, fifo_rd_en})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: ;
            endcase
        end
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_words  = 0;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [2:0] c, input logic l);
        exp_t e;
        e.d = d; e.c = c; e.l = l;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en  = 1'b1;
            wr_dat = first + 8'(i);
            step(1);
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (!(sb.size() == 0 && !busy && fifo_empty) && k < budget) begin
            step(1);
            k++;
        end
        if (k >= budget) chk(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_pops(input string tag, input int base, input int n);
        int k;
        k = 0;
        while ((pop_cnt - base) < n && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk(tag, 64'(pop_cnt - base), 64'(n));
    endtask

    // Scoreboard monitor: every cycle a word is presented it must match the head entry.
    always @(negedge clk) begin
        if (!rst && m_valid) begin
            if (sb.size() == 0) begin
                chk("unexp_word", 64'd1, 64'd0);
            end else begin
                chk("m_data", 64'(m_data), 64'(sb[0].d));
                chk("m_count", 64'(m_count), 64'(sb[0].c));
                chk("m_last", 64'(m_last), 64'(sb[0].l));
                if (m_ready) begin
                    mon_e = sb.pop_front();
                    n_words++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cyc;
        rst = 1'b1; fifo_clr = 1'b1; wr_en = 1'b0; wr_dat = '0; flush = 1'b0; m_ready = 1'b1;
        step(3);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_count", 64'(m_count), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        rst = 1'b0; fifo_clr = 1'b0;
        step(1);

        // Two full words.
        base = pop_cnt;
        push_exp(32'h04030201, 3'd4, 1'b0);
        push_exp(32'h08070605, 3'd4, 1'b0);
        write_seq(8'h01, 8);
        wait_idle("full_words_timeout", 100);
        chk("full_pops", 64'(pop_cnt - base), 64'd8);

        // Partial word by flush, busy falls after the transfer.
        push_exp(32'h00332211, 3'd3, 1'b1);
        wr_en = 1'b1; wr_dat = 8'h11; step(1);
        wr_dat = 8'h22; step(1);
        wr_dat = 8'h33; step(1);
        wr_en = 1'b0;
        step(6);
        chk("pre_flush_busy", 64'(busy), 64'd1);
        flush = 1'b1; step(1); flush = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!m_valid && cyc < 20);
        chk("flush_word_seen", 64'(m_valid), 64'd1);
        chk("busy_at_xfer", 64'(busy), 64'd1);
        @(negedge clk);
        chk("busy_fall", 64'(busy), 64'd0);
        step(1);

        // Backpressure: 16 entries with m_ready low.
        m_ready = 1'b0;
        base = pop_cnt;
        for (int w = 0; w < 4; w++)
            push_exp({8'(8'h33 + 4*w), 8'(8'h32 + 4*w), 8'(8'h31 + 4*w), 8'(8'h30 + 4*w)}, 3'd4, 1'b0);
        write_seq(8'h30, 16);
        step(20);
        chk("stall_vld", 64'(m_valid), 64'd1);
        chk("stall_pops", 64'(pop_cnt - base), 64'd8);
        chk("stall_fifo_lvl", 64'(fcnt), 64'd8);
        chk("stall_rd_en", 64'(fifo_rd_en), 64'd0);
        m_ready = 1'b1;
        wait_idle("drain_timeout", 200);
        chk("drain_pops", 64'(pop_cnt - base), 64'd16);

        // Flush with an empty accumulator emits nothing.
        base = n_words;
        flush = 1'b1; step(1); flush = 1'b0;
        step(10);
        chk("empty_flush_words", 64'(n_words - base), 64'd0);
        chk("empty_flush_busy", 64'(busy), 64'd0);

        // Flush on the cycle the 4th entry is captured.
        base = pop_cnt;
        push_exp(32'h44434241, 3'd4, 1'b1);
        write_seq(8'h41, 4);
        wait_pops("cap4_pop_timeout", base, 4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        step(1);
        wait_idle("cap4_flush_timeout", 100);

        // Reset mid-word with a word also held in the output register.
        m_ready = 1'b0;
        base = pop_cnt;
        push_exp(32'h94939291, 3'd4, 1'b0);
        write_seq(8'h91, 6);
        wait_pops("rst_pop_timeout", base, 6);
        step(2);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        sb.delete();
        step(1);
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_m_data", 64'(m_data), 64'd0);
        chk("midrst_m_count", 64'(m_count), 64'd0);
        chk("midrst_m_last", 64'(m_last), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        m_ready = 1'b1;
        step(1);
        push_exp(32'hA3A2A1A0, 3'd4, 1'b0);
        write_seq(8'hA0, 4);
        wait_idle("post_rst_timeout", 100);

`ifdef ALIB_FIFO_PACKER_TIMEOUT_EN
        // Idle auto-flush of a lone entry.
        base = pop_cnt;
        push_exp(32'h00000055, 3'd1, 1'b1);
        write_seq(8'h55, 1);
        wait_pops("tmo_pop_timeout", base, 1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!m_valid && cyc < 40);
        chk("tmo_latency_ok", 64'((cyc >= 8) && (cyc <= 13)), 64'd1);
        step(1);
        wait_idle("tmo_timeout", 60);
`endif

        chk("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
